video_timing_gen: RTL and testbench

Generates the raster timing and the frame-buffer read strobe that feed the brightness/contrast pipeline's o_vs/o_hs/o_de/rd_data inputs. It is the producing end of that video interface.
- rd_en pops pixels from the read FIFO READ_LAT cycles ahead of o_de, so FIFO data and timing arrive aligned at the consumer.
- Default timing is 1280x720p60 at 74.25 MHz.
- It also reports FIFO underflow.

---
 rtl/video_timing_gen_pkg.sv | 57 +++++
 rtl/vtg_delay_line.sv | 41 ++++
 rtl/video_timing_gen.sv | 196 +++++++++++++++++++
 tb/tb_video_timing_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_pkg
// Description : Shared timing constants, derived totals, the generator
//               state enum and the stage-0 timing record used by
//               video_timing_gen and its delay line.
//               Defaults describe 1280x720p60 at a 74.25 MHz pixel clock.
// Revision    : 1.0 - initial release
// ============================================================================
package video_timing_gen_pkg;

  // Width of the raster counters and of x_pos / y_pos.
  localparam int CNT_W = 12;

  // Default horizontal timing, in pixel clocks.
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;

  // Default vertical timing, in lines.
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  // Default sync polarities (1 = sync pulse is a high level).
  localparam bit DEF_HS_POL = 1'b1;
  localparam bit DEF_VS_POL = 1'b1;

  // Total period of one axis: active + front porch + sync + back porch.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Generator state: counters parked at zero, or scanning the raster.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vtg_state_e;

  // One pixel-clock worth of timing. hs/vs carry the output line level
  // (polarity already applied), not the "in sync region" flag.
  typedef struct packed {
    logic             de;
    logic             hs;
    logic             vs;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } vtg_timing_t;

endpackage : video_timing_gen_pkg
`default_nettype wire

// File: rtl/vtg_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vtg_delay_line
// Description : Fixed-depth register shift line. Every tap clears to
//               RESET_VAL on rst, so a reset flushes everything in flight.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               din  - data entering the line
//               dout - din delayed by exactly DEPTH clocks
// Revision    : 1.0 - initial release
// ============================================================================
module vtg_delay_line #(
  parameter int               DEPTH     = 1,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_taps [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_taps[i] <= RESET_VAL;
      end
    end else begin
      r_taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_taps[i] <= r_taps[i-1];
      end
    end
  end

  assign dout = r_taps[DEPTH-1];

endmodule : vtg_delay_line
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Raster timing generator and frame-buffer read strobe.
//               rd_en pops the read FIFO READ_LAT clocks ahead of o_de so
//               FIFO data and timing reach the consumer aligned. Also keeps
//               a sticky FIFO underflow flag.
// Ports       : clk_74      - pixel clock (74.25 MHz for the default mode)
//               rst         - synchronous active-high reset
//               gen_en      - generator enable; dropping it finishes the frame
//               fifo_empty  - read FIFO empty flag
//               rd_en       - FIFO read strobe, one per active pixel
//               o_hs, o_vs  - sync outputs, active level HS_POL / VS_POL
//               o_de        - data enable, aligned with FIFO read data
//               x_pos/y_pos - pixel column / row, valid while o_de
//               frame_start - one-cycle pulse on the first o_de of a frame
//               underflow   - sticky: rd_en seen while FIFO empty
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = DEF_HS_POL,
  parameter bit VS_POL   = DEF_VS_POL,
  // FIFO read latency in clocks, legal range 1..4.
  parameter int READ_LAT = 1
) (
  input  logic             clk_74,
  input  logic             rst,
  input  logic             gen_en,
  input  logic             fifo_empty,
  output logic             rd_en,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  output logic             frame_start,
  output logic             underflow
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Region boundaries at counter width; *_END values are exclusive.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Stage-0 value while not scanning; also the delay line's reset value so
  // the outputs come out of reset at their idle levels.
  localparam vtg_timing_t IDLE_TIMING = '{
    de: 1'b0,
    hs: ~HS_POL,
    vs: ~VS_POL,
    x:  '0,
    y:  '0
  };

  vtg_state_e       r_state;
  vtg_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_active;
  logic             w_hs_region;
  logic             w_vs_region;
  vtg_timing_t      r_stage0;
  vtg_timing_t      w_delayed;
  logic             r_underflow;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  // --------------------------------------------------------------------------
  // State machine: leaving RUN is only allowed on the last pixel of a frame,
  // so a mid-frame gen_en drop always completes the frame in progress.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_74) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (gen_en) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_h_last && w_v_last && !gen_en) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Raster counters. Held at zero outside RUN so every run starts at the
  // top-left pixel. The last pixel of a frame wraps both to zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_74) begin
    if (rst || (r_state != RUN)) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : (r_v_cnt + CNT_W'(1));
    end else begin
      r_h_cnt <= r_h_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Region decode and stage 0. vs depends on v_cnt alone, so it changes on
  // the h_cnt = 0 cycle together with v_cnt and spans whole lines.
  // --------------------------------------------------------------------------
  assign w_active    = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
  assign w_hs_region = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
  assign w_vs_region = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);

  always_ff @(posedge clk_74) begin
    if (rst || (r_state != RUN)) begin
      r_stage0 <= IDLE_TIMING;
    end else begin
      r_stage0.de <= w_active;
      r_stage0.hs <= w_hs_region ? HS_POL : ~HS_POL;
      r_stage0.vs <= w_vs_region ? VS_POL : ~VS_POL;
      r_stage0.x  <= r_h_cnt;
      r_stage0.y  <= r_v_cnt;
    end
  end

  assign rd_en = r_stage0.de;

  // --------------------------------------------------------------------------
  // Align timing with FIFO read data: READ_LAT further clocks after rd_en.
  // --------------------------------------------------------------------------
  vtg_delay_line #(
    .DEPTH     (READ_LAT),
    .WIDTH     ($bits(vtg_timing_t)),
    .RESET_VAL (IDLE_TIMING)
  ) u_delay (
    .clk  (clk_74),
    .rst  (rst),
    .din  (r_stage0),
    .dout (w_delayed)
  );

  assign o_de  = w_delayed.de;
  assign o_hs  = w_delayed.hs;
  assign o_vs  = w_delayed.vs;
  assign x_pos = w_delayed.x;
  assign y_pos = w_delayed.y;

  // Top-left active pixel as seen at the consumer.
  assign frame_start = w_delayed.de && (w_delayed.x == '0) && (w_delayed.y == '0);

  // --------------------------------------------------------------------------
  // Sticky underflow: a pop issued while the FIFO is empty. Purely a status
  // flag; rd_en and the timing are never gated by it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_74) begin
    if (rst) begin
      r_underflow <= 1'b0;
    end else if (rd_en && fifo_empty) begin
      r_underflow <= 1'b1;
    end
  end

  assign underflow = r_underflow;

endmodule : video_timing_gen
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Self-checking bench for video_timing_gen. Two instances share
//               the stimulus: A uses READ_LAT = 1 with active-high syncs,
//               B uses READ_LAT = 3 with active-low syncs. A small raster
//               keeps whole frames short. The reference model describes the
//               raster as a linear pixel index within the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  localparam int HA  = 16, HFP = 3, HSW = 4, HBP = 5;
  localparam int VA  = 6,  VFP = 2, VSW = 2, VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, gen_en, fifo_empty;

  logic        a_rd_en, a_hs, a_vs, a_de, a_fs, a_uf;
  logic [11:0] a_x, a_y;
  logic        b_rd_en, b_hs, b_vs, b_de, b_fs, b_uf;
  logic [11:0] b_x, b_y;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .READ_LAT(1)
  ) dut_a (
    .clk_74(clk), .rst(rst), .gen_en(gen_en), .fifo_empty(fifo_empty),
    .rd_en(a_rd_en), .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de),
    .x_pos(a_x), .y_pos(a_y), .frame_start(a_fs), .underflow(a_uf)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .READ_LAT(LAT_B)
  ) dut_b (
    .clk_74(clk), .rst(rst), .gen_en(gen_en), .fifo_empty(fifo_empty),
    .rd_en(b_rd_en), .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de),
    .x_pos(b_x), .y_pos(b_y), .frame_start(b_fs), .underflow(b_uf)
  );

  // Expected stage-0 content for one clock; t = index within frame, -1 idle.
  typedef struct {
    bit de;
    bit hs;
    bit vs;
    int x;
    int y;
    int t;
  } samp_t;

  samp_t hist [0:4];   // hist[0] = value presented as rd_en now, hist[k] = k clocks older
  bit    m_run;
  int    m_t;
  bit    m_uf;

  int n_assert = 0;
  int n_fail   = 0;

  bit stat_on = 1'b0;
  int cyc = 0, last_fs = -1, de_acc = 0;

  function automatic samp_t pixel(input int t);
    samp_t s;
    int h, v;
    s = '{de: 1'b0, hs: 1'b0, vs: 1'b0, x: 0, y: 0, t: -1};
    if (t >= 0) begin
      h    = t % HT;
      v    = t / HT;
      s.de = (h < HA) && (v < VA);
      s.hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
      s.vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
      s.x  = h;
      s.y  = v;
      s.t  = t;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    samp_t ea, eb;
    ea = hist[1];
    eb = hist[LAT_B];
    chk("a_rd_en", {31'd0, a_rd_en}, {31'd0, hist[0].de});
    chk("a_de",    {31'd0, a_de},    {31'd0, ea.de});
    chk("a_hs",    {31'd0, a_hs},    {31'd0, ea.hs});
    chk("a_vs",    {31'd0, a_vs},    {31'd0, ea.vs});
    chk("a_fs",    {31'd0, a_fs},    (ea.t == 0) ? 32'd1 : 32'd0);
    chk("a_uf",    {31'd0, a_uf},    {31'd0, m_uf});
    if (ea.de) begin
      chk("a_x", {20'd0, a_x}, ea.x);
      chk("a_y", {20'd0, a_y}, ea.y);
    end
    chk("b_rd_en", {31'd0, b_rd_en}, {31'd0, hist[0].de});
    chk("b_de",    {31'd0, b_de},    {31'd0, eb.de});
    chk("b_hs",    {31'd0, b_hs},    {31'd0, !eb.hs});
    chk("b_vs",    {31'd0, b_vs},    {31'd0, !eb.vs});
    chk("b_fs",    {31'd0, b_fs},    (eb.t == 0) ? 32'd1 : 32'd0);
    chk("b_uf",    {31'd0, b_uf},    {31'd0, m_uf});
    if (eb.de) begin
      chk("b_x", {20'd0, b_x}, eb.x);
      chk("b_y", {20'd0, b_y}, eb.y);
    end
  endtask

  // One clock: sample inputs, advance the model across the edge, then check.
  task automatic tick();
    bit rs, ge, fe;
    rs = rst;
    ge = gen_en;
    fe = fifo_empty;
    @(posedge clk);
    if (rs) begin
      m_run = 1'b0;
      m_t   = 0;
      m_uf  = 1'b0;
      for (int k = 0; k <= 4; k++) hist[k] = pixel(-1);
    end else begin
      if (hist[0].de && fe) m_uf = 1'b1;
      for (int k = 4; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = m_run ? pixel(m_t) : pixel(-1);
      if (m_run) begin
        if ((m_t == FT - 1) && !ge) m_run = 1'b0;
        m_t = (m_t + 1) % FT;
      end else if (ge) begin
        m_run = 1'b1;
      end
    end
    #1;
    check_outputs();
    cyc++;
    if (stat_on) begin
      if (a_fs) begin
        if (last_fs >= 0) begin
          chk("fs_period",    cyc - last_fs, FT);
          chk("de_per_frame", de_acc,        HA * VA);
        end
        last_fs = cyc;
        de_acc  = 0;
      end
      if (a_de) de_acc++;
    end
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    gen_en     = 1'b1;
    fifo_empty = 1'b0;
    m_run      = 1'b0;
    m_t        = 0;
    m_uf       = 1'b0;
    for (int k = 0; k <= 4; k++) hist[k] = pixel(-1);

    // Reset held with gen_en high: everything idle.
    repeat (10) tick();

    // Release: rd_en on the 2nd edge, A's o_de one edge later, B's three.
    rst = 1'b0;
    tick();
    chk("first_edge_rd_en", {31'd0, a_rd_en}, 32'd0);
    tick();
    chk("second_edge_rd_en", {31'd0, a_rd_en}, 32'd1);
    chk("second_edge_de",    {31'd0, a_de},    32'd0);
    tick();
    chk("a_de_rise",  {31'd0, a_de}, 32'd1);
    chk("a_fs_first", {31'd0, a_fs}, 32'd1);
    chk("b_de_early", {31'd0, b_de}, 32'd0);
    tick();
    tick();
    chk("b_de_rise",  {31'd0, b_de}, 32'd1);
    chk("b_fs_first", {31'd0, b_fs}, 32'd1);

    // Continuous frames: frame_start period and o_de count per frame.
    stat_on = 1'b1;
    repeat (3 * FT) tick();
    stat_on = 1'b0;

    // Drop gen_en at a random mid-frame point; the frame must complete.
    repeat ($urandom_range(FT / 4, FT / 2)) tick();
    gen_en = 1'b0;
    repeat (FT + 40) tick();
    chk("idle_rd_en", {31'd0, a_rd_en}, 32'd0);

    // Restart, with an empty pulse while rd_en is still low (no underflow).
    gen_en     = 1'b1;
    fifo_empty = 1'b1;
    tick();
    fifo_empty = 1'b0;
    tick();
    chk("no_uf_blank", {31'd0, a_uf}, 32'd0);

    // Single empty pulse inside active video of the first line.
    repeat ($urandom_range(2, HA - 4)) tick();
    fifo_empty = 1'b1;
    tick();
    fifo_empty = 1'b0;
    chk("uf_set", {31'd0, a_uf}, 32'd1);
    repeat (FT) tick();
    chk("uf_sticky", {31'd0, a_uf}, 32'd1);

    // Reset mid-frame aborts at once and clears underflow.
    repeat ($urandom_range(10, FT / 2)) tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("uf_cleared", {31'd0, a_uf}, 32'd0);
    rst = 1'b0;

    // Randomised enable / empty / occasional reset traffic.
    n = 2500;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 299) == 0) gen_en = ~gen_en;
      fifo_empty = ($urandom_range(0, 199) == 0);
      rst        = ($urandom_range(0, 999) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_video_timing_gen
`default_nettype wire
